// File: rtl/axis_stream_rr_arbiter_pkg.sv
// Shared types and helpers for the AXI4-Stream round-robin arbiters.
package axis_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int unsigned MAX_CHANNELS   = 16;
  localparam int unsigned MAX_KEEP_WIDTH = 128;
  localparam logic [MAX_KEEP_WIDTH-1:0] TKEEP_ALL = '1;

  // Compare-and-subtract wrap; idx is always below 2*n here.
  function automatic int unsigned rr_wrap(int unsigned idx, int unsigned n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

  // First requesting index after 'last', wrapping at n; returns 'last' when
  // nothing requests. Indices at or above n are never produced.
  function automatic int unsigned rr_next(int unsigned last,
                                          logic [MAX_CHANNELS-1:0] req,
                                          int unsigned n);
    int unsigned result;
    int unsigned idx;
    logic        found;
    result = last;
    found  = 1'b0;
    for (int unsigned i = 1; i <= MAX_CHANNELS; i++) begin
      if (i <= n) begin
        idx = rr_wrap(last + i, n);
        if (!found && req[idx[3:0]]) begin
          result = idx;
          found  = 1'b1;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_stream_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: request vector + last grant -> next grant.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned CH_BITS      = $clog2(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic [CH_BITS-1:0]      last_grant,
  output logic [CH_BITS-1:0]      grant,
  output logic                    any_req
);

  logic [MAX_CHANNELS-1:0] req_ext;

  always_comb begin
    req_ext                   = '0;
    req_ext[NUM_CHANNELS-1:0] = req;
    grant   = CH_BITS'(rr_next(32'(last_grant), req_ext, NUM_CHANNELS));
    any_req = |req;
  end

endmodule

// File: rtl/axis_stream_rr_arbiter.sv
// N-channel packet round-robin arbiter onto one registered AXI4-Stream master.
// Optional per-channel packet counters: define AXIS_RR_ARB_STATS_EN.
module axis_stream_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned DEST_WIDTH   = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CHANNELS-1:0]          ch_valid,
  output logic [NUM_CHANNELS-1:0]          ch_ready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
  input  logic [NUM_CHANNELS-1:0]          ch_last,
  output logic [DATA_WIDTH-1:0]            stream_tdata,
  output logic [DEST_WIDTH-1:0]            stream_tdest,
  output logic [DATA_WIDTH/8-1:0]          stream_tkeep,
  output logic                             stream_tlast,
  output logic                             stream_tvalid,
  input  logic                             stream_tready,
  output logic                             busy
`ifdef AXIS_RR_ARB_STATS_EN
  ,
  input  logic                             stats_clear,
  output logic [NUM_CHANNELS*16-1:0]       pkt_count
`endif
);

  localparam int unsigned CH_BITS = $clog2(NUM_CHANNELS);
  localparam int unsigned KEEP_W  = DATA_WIDTH / 8;

  arb_state_t              state_q, state_d;
  logic [CH_BITS-1:0]      last_grant_q, last_grant_d;
  logic [CH_BITS-1:0]      lock_ch_q, lock_ch_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [CH_BITS-1:0]      tdest_q, tdest_d;
  logic                    tlast_q, tlast_d;
  logic                    tvalid_q, tvalid_d;

  logic                    load_en;
  logic [CH_BITS-1:0]      pick_grant;
  logic                    any_req;
  logic [CH_BITS-1:0]      cur_grant;
  logic                    grant_live;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_last;
  logic                    accept;

  rr_pick #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CH_BITS      (CH_BITS)
  ) u_rr_pick (
    .req        (ch_valid),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .any_req    (any_req)
  );

  always_comb begin
    load_en    = !tvalid_q || stream_tready;
    cur_grant  = (state_q == LOCKED) ? lock_ch_q : pick_grant;
    grant_live = (state_q == LOCKED) || any_req;
    ch_ready   = '0;
    sel_data   = '0;
    sel_last   = 1'b0;
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      if (CH_BITS'(k) == cur_grant) begin
        ch_ready[k] = load_en && grant_live;
        sel_data    = ch_data[k*DATA_WIDTH +: DATA_WIDTH];
        sel_last    = ch_last[k];
      end
    end
    accept = |(ch_valid & ch_ready);
  end

  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tdest_d  = tdest_q;
    if (load_en) begin
      tvalid_d = accept;
      if (accept) begin
        tdata_d = sel_data;
        tlast_d = sel_last;
        tdest_d = cur_grant;
      end
    end
  end

  // The next grant is taken from last_grant_q, so it is chosen the cycle after a last beat.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_ch_d    = lock_ch_q;
    if (accept) begin
      if (sel_last) begin
        state_d      = IDLE;
        last_grant_d = cur_grant;
      end else if (state_q == IDLE) begin
        state_d   = LOCKED;
        lock_ch_d = cur_grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= CH_BITS'(NUM_CHANNELS - 1);
      lock_ch_q    <= '0;
      tdata_q      <= '0;
      tdest_q      <= '0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_ch_q    <= lock_ch_d;
      tdata_q      <= tdata_d;
      tdest_q      <= tdest_d;
      tlast_q      <= tlast_d;
      tvalid_q     <= tvalid_d;
    end
  end

  assign stream_tdata  = tdata_q;
  assign stream_tdest  = DEST_WIDTH'(tdest_q);
  assign stream_tkeep  = TKEEP_ALL[KEEP_W-1:0];
  assign stream_tlast  = tlast_q;
  assign stream_tvalid = tvalid_q;
  assign busy          = (state_q == LOCKED);

`ifdef AXIS_RR_ARB_STATS_EN
  logic [NUM_CHANNELS*16-1:0] pkt_count_q, pkt_count_d;

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (stats_clear) begin
      pkt_count_d = '0;
    end else if (accept && sel_last) begin
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
        if (CH_BITS'(k) == cur_grant) begin
          pkt_count_d[k*16 +: 16] = pkt_count_q[k*16 +: 16] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule
